pq_dequeue_ctrl: RTL and testbench

Dequeue-side controller for the BRAM-backed sorted priority queue. It is the removal counterpart of the insertion compare/route path. On request it reads the head entry (index 0, the smallest), returns it to the requester, then shifts entries 1..n-1 down one slot. It writes SENTINEL into the vacated tail slot. It owns the BRAM read and write ports while busy, and raises busy so the enqueue path holds off.

---
 rtl/pq_deq_if.sv | 35 +++
 rtl/pq_dequeue_ctrl.sv | 139 +++++++++++++
 tb/tb_pq_dequeue_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_deq_if.sv
// Dequeue-side bundle: requester handshake plus the BRAM read/write ports
// the controller owns while busy.
interface pq_deq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              deq_req;
  logic              deq_ready;
  logic [ADDR_W:0]   q_count;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_data;
  logic              deq_empty;
  logic              deq_done;
  logic              busy;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;

  // master: requester / BRAM side
  modport master (
    output deq_req, q_count, ram_rd_data,
    input  deq_ready, deq_valid, deq_data, deq_empty, deq_done, busy,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  // slave: dequeue controller
  modport slave (
    input  deq_req, q_count, ram_rd_data,
    output deq_ready, deq_valid, deq_data, deq_empty, deq_done, busy,
           ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/pq_dequeue_ctrl.sv
// Sorted-queue dequeue: read head, return it, shift 1..n-1 down, write SENTINEL
// at the tail. States: IDLE wait, HEAD return head, SHIFT move down, FLUSH tail.
module pq_dequeue_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] SENTINEL = {DATA_W{1'b1}}
) (
  input logic     clk,
  input logic     rst,
  pq_deq_if.slave bus
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAD  = 2'd1,
    SHIFT = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     j_q, j_d;
  logic              deq_valid_q, deq_valid_d;
  logic [DATA_W-1:0] deq_data_q, deq_data_d;
  logic              deq_empty_q, deq_empty_d;

  logic              deq_ready;
  logic              accept;
  logic [CW-1:0]     j_inc;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign deq_ready = (state_q == IDLE) && !rst;
  assign accept    = bus.deq_req && deq_ready;
  // j is one bit wider than an address so j+1 can reach DEPTH without wrapping
  assign j_inc     = j_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    j_d         = j_q;
    deq_valid_d = 1'b0;
    deq_data_d  = deq_data_q;
    deq_empty_d = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.q_count != '0) begin
            rd_en   = 1'b1;
            rd_addr = '0;
            n_d     = bus.q_count;
            j_d     = CW'(1);
            state_d = HEAD;
          end else begin
            deq_empty_d = 1'b1;
          end
        end
      end

      HEAD: begin
        deq_data_d  = bus.ram_rd_data;
        deq_valid_d = 1'b1;
        if (n_q > CW'(1)) begin
          rd_en   = 1'b1;
          rd_addr = ADDR_W'(1);
          state_d = SHIFT;
        end else begin
          state_d = FLUSH;
        end
      end

      SHIFT: begin
        // entry j arrives now; it lands one slot lower while j+1 is fetched
        wr_en   = 1'b1;
        wr_addr = j_q[ADDR_W-1:0] - ADDR_W'(1);
        wr_data = bus.ram_rd_data;
        if (j_inc < n_q) begin
          rd_en   = 1'b1;
          rd_addr = j_inc[ADDR_W-1:0];
          j_d     = j_inc;
        end else begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        wr_en   = 1'b1;
        wr_addr = n_q[ADDR_W-1:0] - ADDR_W'(1);
        wr_data = SENTINEL;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      j_q         <= '0;
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
      deq_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      j_q         <= j_d;
      deq_valid_q <= deq_valid_d;
      deq_data_q  <= deq_data_d;
      deq_empty_q <= deq_empty_d;
    end
  end

  assign bus.deq_ready   = deq_ready;
  assign bus.deq_valid   = deq_valid_q;
  assign bus.deq_data    = deq_data_q;
  assign bus.deq_empty   = deq_empty_q;
  assign bus.deq_done    = (state_q == FLUSH);
  assign bus.busy        = (state_q != IDLE);
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_addr;
  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_wr_addr = wr_addr;
  assign bus.ram_wr_data = wr_data;

endmodule

// File: tb/tb_pq_dequeue_ctrl.sv
// Directed bench for pq_dequeue_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_pq_dequeue_ctrl;

  localparam int DW = 16;
  localparam int DP = 64;
  localparam int AW = 6;
  localparam int NC = 80;
  localparam logic [DW-1:0] SENT = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pq_deq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pq_dequeue_ctrl #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .SENTINEL(SENT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] load_img [DP];
  logic          load_en = 1'b0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < DP; k++) mem[k] <= load_img[k];
    end else if (bus.ram_wr_en) begin
      mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    end
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  logic          c_rd_en   [NC];
  logic [AW-1:0] c_rd_addr [NC];
  logic          c_wr_en   [NC];
  logic [AW-1:0] c_wr_addr [NC];
  logic [DW-1:0] c_wr_data [NC];
  logic          c_valid   [NC];
  logic [DW-1:0] c_data    [NC];
  logic          c_empty   [NC];
  logic          c_done    [NC];
  logic          c_busy    [NC];
  logic          c_ready   [NC];

  task automatic load_ram();
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.deq_req = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Cycle 0 is the cycle in which the caller has already raised deq_req.
  task automatic capture(input int ncyc, input int drop_at, input int q2_at,
                         input logic [AW:0] q2, input int rst_at);
    for (int i = 0; i < ncyc; i++) begin
      if (i == drop_at) bus.deq_req = 1'b0;
      if (i == q2_at) bus.q_count = q2;
      if (i == rst_at) rst = 1'b1;
      if (i == rst_at + 1) rst = 1'b0;
      @(negedge clk);
      c_rd_en[i]   = bus.ram_rd_en;
      c_rd_addr[i] = bus.ram_rd_addr;
      c_wr_en[i]   = bus.ram_wr_en;
      c_wr_addr[i] = bus.ram_wr_addr;
      c_wr_data[i] = bus.ram_wr_data;
      c_valid[i]   = bus.deq_valid;
      c_data[i]    = bus.deq_data;
      c_empty[i]   = bus.deq_empty;
      c_done[i]    = bus.deq_done;
      c_busy[i]    = bus.busy;
      c_ready[i]   = bus.deq_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.deq_req = 1'b1;
    bus.q_count = 7'd4;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({bus.deq_ready, bus.busy, bus.deq_valid, bus.deq_empty, bus.deq_done,
         bus.ram_rd_en, bus.ram_wr_en} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/busy/val/emp/done/rd/wr=%b required 0000000",
               {bus.deq_ready, bus.busy, bus.deq_valid, bus.deq_empty, bus.deq_done,
                bus.ram_rd_en, bus.ram_wr_en});
    end
    vectors++;
    if (bus.deq_data !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0000", bus.deq_data);
    end
    @(posedge clk); #1;
    bus.deq_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.deq_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b busy=%b required 1 0", bus.deq_ready, bus.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_four();
    logic [DW-1:0] wd [4];
    logic          we;
    wd = '{16'd7, 16'd9, 16'd12, SENT};
    for (int k = 0; k < DP; k++) load_img[k] = 16'hAAAA;
    load_img[0] = 16'd3; load_img[1] = 16'd7; load_img[2] = 16'd9; load_img[3] = 16'd12;
    load_ram();
    bus.q_count = 7'd4;
    bus.deq_req = 1'b1;
    capture(8, 1, -5, 7'd0, -5);
    vectors++;
    if (c_ready[0] !== 1'b1 || c_rd_en[0] !== 1'b1 || c_rd_addr[0] !== 6'd0) begin
      miscompares++;
      $display("FAIL four_accept: got ready=%b rd_en=%b addr=%0d required 1 1 0",
               c_ready[0], c_rd_en[0], c_rd_addr[0]);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (c_valid[i] !== (i == 2) || (i == 2 && c_data[i] !== 16'd3)) begin
        miscompares++;
        $display("FAIL four_valid cyc%0d: got valid=%b data=%h required %b 0003",
                 i, c_valid[i], c_data[i], (i == 2));
      end
      we = (i >= 2 && i <= 5);
      vectors++;
      if (c_wr_en[i] !== we || (we && (c_wr_addr[i] !== 6'(i - 2) || c_wr_data[i] !== wd[i-2]))) begin
        miscompares++;
        $display("FAIL four_write cyc%0d: got en=%b addr=%0d data=%h required en=%b",
                 i, c_wr_en[i], c_wr_addr[i], c_wr_data[i], we);
      end
      vectors++;
      if (c_done[i] !== (i == 5) || c_busy[i] !== (i >= 1 && i <= 5)) begin
        miscompares++;
        $display("FAIL four_done_busy cyc%0d: got done=%b busy=%b required %b %b",
                 i, c_done[i], c_busy[i], (i == 5), (i >= 1 && i <= 5));
      end
    end
    vectors++;
    if (c_ready[6] !== 1'b1) begin
      miscompares++;
      $display("FAIL four_ready_return: got %b required 1", c_ready[6]);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (mem[k] !== wd[k]) begin
        miscompares++;
        $display("FAIL four_ram[%0d]: got %h required %h", k, mem[k], wd[k]);
      end
    end
  endtask

  task automatic test_single();
    load_img[0] = 16'h0042;
    load_ram();
    bus.q_count = 7'd1;
    bus.deq_req = 1'b1;
    capture(4, 1, -5, 7'd0, -5);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (c_valid[i] !== (i == 2) || (i == 2 && c_data[i] !== 16'h0042)) begin
        miscompares++;
        $display("FAIL single_valid cyc%0d: got valid=%b data=%h required %b 0042",
                 i, c_valid[i], c_data[i], (i == 2));
      end
      vectors++;
      if (c_wr_en[i] !== (i == 2) || (i == 2 && (c_wr_addr[i] !== 6'd0 || c_wr_data[i] !== SENT))) begin
        miscompares++;
        $display("FAIL single_write cyc%0d: got en=%b addr=%0d data=%h required en=%b (0,ffff)",
                 i, c_wr_en[i], c_wr_addr[i], c_wr_data[i], (i == 2));
      end
      vectors++;
      if (c_done[i] !== (i == 2) || c_rd_en[i] !== (i == 0)) begin
        miscompares++;
        $display("FAIL single_done_rd cyc%0d: got done=%b rd_en=%b required %b %b",
                 i, c_done[i], c_rd_en[i], (i == 2), (i == 0));
      end
    end
  endtask

  task automatic test_empty();
    bus.q_count = 7'd0;
    bus.deq_req = 1'b1;
    capture(3, 1, -5, 7'd0, -5);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (c_empty[i] !== (i == 1)) begin
        miscompares++;
        $display("FAIL empty_pulse cyc%0d: got %b required %b", i, c_empty[i], (i == 1));
      end
      vectors++;
      if ({c_rd_en[i], c_wr_en[i], c_valid[i], c_busy[i], c_ready[i]} !== 5'b00001) begin
        miscompares++;
        $display("FAIL empty_quiet cyc%0d: got rd/wr/val/busy/ready=%b required 00001", i,
                 {c_rd_en[i], c_wr_en[i], c_valid[i], c_busy[i], c_ready[i]});
      end
    end
    vectors++;
    if (c_data[2] !== 16'h0042) begin
      miscompares++;
      $display("FAIL empty_data_hold: got %h required 0042", c_data[2]);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < DP; k++) load_img[k] = 16'h5555;
    load_img[0] = 16'd3; load_img[1] = 16'd7; load_img[2] = 16'd9; load_img[3] = 16'd12;
    load_ram();
    bus.q_count = 7'd4;
    bus.deq_req = 1'b1;
    // q_count changes to 3 while busy; the first dequeue must still use n=4
    capture(13, 7, 1, 7'd3, -5);
    vectors++;
    if (c_ready[6] !== 1'b1 || c_rd_en[6] !== 1'b1 || c_rd_addr[6] !== 6'd0) begin
      miscompares++;
      $display("FAIL b2b_second_accept: got ready=%b rd_en=%b addr=%0d required 1 1 0",
               c_ready[6], c_rd_en[6], c_rd_addr[6]);
    end
    for (int i = 0; i < 13; i++) begin
      vectors++;
      if (c_valid[i] !== (i == 2 || i == 8) ||
          (i == 2 && c_data[i] !== 16'd3) || (i == 8 && c_data[i] !== 16'd7)) begin
        miscompares++;
        $display("FAIL b2b_valid cyc%0d: got valid=%b data=%h", i, c_valid[i], c_data[i]);
      end
      vectors++;
      if (c_done[i] !== (i == 5 || i == 10)) begin
        miscompares++;
        $display("FAIL b2b_done cyc%0d: got %b required %b", i, c_done[i], (i == 5 || i == 10));
      end
    end
    vectors++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {16'd9, 16'd12, SENT, SENT}) begin
      miscompares++;
      $display("FAIL b2b_ram: got %h %h %h %h required 0009 000c ffff ffff",
               mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < DP; k++) load_img[k] = 16'h0;
    load_img[0] = 16'd3; load_img[1] = 16'd7; load_img[2] = 16'd9; load_img[3] = 16'd12;
    load_ram();
    bus.q_count = 7'd4;
    bus.deq_req = 1'b1;
    capture(8, 1, -5, 7'd0, 3);
    vectors++;
    if (c_busy[4] !== 1'b0 || c_wr_en[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_abort: got busy=%b wr_en=%b at C+4 required 0 0", c_busy[4], c_wr_en[4]);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (c_done[i] !== 1'b0 || (i >= 4 && (c_ready[i] !== 1'b1 || c_wr_en[i] !== 1'b0))) begin
        miscompares++;
        $display("FAIL rstmid_after cyc%0d: got done=%b ready=%b wr_en=%b", i, c_done[i],
                 c_ready[i], c_wr_en[i]);
      end
    end
    vectors++;
    if (c_ready[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_ready_in_rst: got %b required 0", c_ready[3]);
    end
  endtask

  task automatic test_full_depth();
    logic we;
    logic [DW-1:0] wd;
    for (int k = 0; k < DP; k++) load_img[k] = 16'(k);
    load_ram();
    bus.q_count = 7'd64;
    bus.deq_req = 1'b1;
    capture(68, 1, -5, 7'd0, -5);
    vectors++;
    if (c_valid[2] !== 1'b1 || c_data[2] !== 16'd0) begin
      miscompares++;
      $display("FAIL full_head: got valid=%b data=%h required 1 0000", c_valid[2], c_data[2]);
    end
    for (int i = 0; i < 68; i++) begin
      vectors++;
      if (c_rd_en[i] !== (i <= 63) || (i <= 63 && c_rd_addr[i] !== 6'(i))) begin
        miscompares++;
        $display("FAIL full_read cyc%0d: got en=%b addr=%0d required en=%b addr=%0d",
                 i, c_rd_en[i], c_rd_addr[i], (i <= 63), i);
      end
      we = (i >= 2 && i <= 65);
      wd = (i == 65) ? SENT : 16'(i - 1);
      vectors++;
      if (c_wr_en[i] !== we || (we && (c_wr_addr[i] !== 6'(i - 2) || c_wr_data[i] !== wd))) begin
        miscompares++;
        $display("FAIL full_write cyc%0d: got en=%b addr=%0d data=%h required en=%b addr=%0d data=%h",
                 i, c_wr_en[i], c_wr_addr[i], c_wr_data[i], we, i - 2, wd);
      end
      vectors++;
      if (c_done[i] !== (i == 65)) begin
        miscompares++;
        $display("FAIL full_done cyc%0d: got %b required %b", i, c_done[i], (i == 65));
      end
    end
    vectors++;
    if (c_ready[66] !== 1'b1) begin
      miscompares++;
      $display("FAIL full_ready_return: got %b required 1", c_ready[66]);
    end
    for (int k = 0; k < DP; k++) begin
      wd = (k == 63) ? SENT : 16'(k + 1);
      vectors++;
      if (mem[k] !== wd) begin
        miscompares++;
        $display("FAIL full_ram[%0d]: got %h required %h", k, mem[k], wd);
      end
    end
  endtask

  initial begin
    bus.deq_req = 1'b0;
    bus.q_count = '0;
    for (int k = 0; k < DP; k++) load_img[k] = '0;
    test_reset();
    test_four();
    idle_cycles(2);
    test_single();
    idle_cycles(2);
    test_empty();
    idle_cycles(2);
    test_back_to_back();
    idle_cycles(2);
    test_reset_mid();
    idle_cycles(2);
    test_full_depth();
    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
